mem_access: RTL and testbench

Memory-access stage that services the load/store requests issued by the execute stage (LW, LB, SW, SB) against the 32-bit asynchronous SRAM. It latches the request, sequences the SRAM strobes through a multi-cycle state machine, and performs byte-lane selection, sign extension and byte-enable generation. It delivers the write-back result together with a stall signal that holds the upstream pipeline until the access completes. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_byte_lane.sv | 31 +++
 rtl/mem_access.sv | 172 +++++++++++++++++
 tb/tb_mem_access.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory-access stage.
//   state_t   - access sequencer states
//   lane_t    - byte lane index within a 32-bit word (addr[1:0])
//   BE_NONE / BE_ALL - active-low byte-enable patterns
//   lane_mask_n() - active-low byte enable selecting a single lane
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    typedef logic [1:0] lane_t;

    localparam logic [3:0] BE_NONE = 4'b1111;
    localparam logic [3:0] BE_ALL  = 4'b0000;

    function automatic logic [3:0] lane_mask_n(input lane_t lane);
        logic [3:0] be;
        be       = BE_NONE;
        be[lane] = 1'b0;
        return be;
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: combinational byte-lane steering for LB/SB and LW/SW.
//   lane      in  byte lane (addr[1:0]); ignored for word accesses
//   load_byte in  1 = byte access, 0 = word access
//   rdata     in  raw SRAM read word
//   wdata     in  store data from the pipeline
//   rd_data   out load result (sign-extended byte or full word)
//   st_data   out data to drive on the SRAM bus
//   be_n      out active-low byte enables for a store
module mem_byte_lane
    import mem_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic        load_byte,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] rd_data,
    output logic [31:0] st_data,
    output logic [3:0]  be_n
);

    logic [7:0] rbyte;

    always_comb begin
        rbyte   = rdata[{lane, 3'b000} +: 8];
        rd_data = load_byte ? {{24{rbyte[7]}}, rbyte} : rdata;
        // The byte is replicated on every lane; be_n picks the one the SRAM keeps.
        st_data = load_byte ? {4{wdata[7:0]}} : wdata;
        be_n    = load_byte ? lane_mask_n(lane_t'(lane)) : BE_ALL;
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage driving a 32-bit asynchronous SRAM.
// Latches a load/store request, sequences the SRAM strobes, and returns a
// one-cycle write-back pulse. Non-memory instructions pass through in one cycle.
//   clk, rst        clock; asynchronous active-high reset
//   addr_i          byte address, or ALU result for non-memory instructions
//   wdata_i         store data
//   mem_read_i      load request (wins over mem_write_i)
//   mem_write_i     store request
//   load_byte_i     1 = LB/SB, 0 = LW/SW
//   reg_write_i     instruction writes a register
//   wreg_i          destination register
//   busy            stall upstream; high whenever not IDLE
//   wb_valid        one-cycle completion pulse
//   wb_reg_write    write-back enable (meaningful with wb_valid)
//   wb_reg, wb_data write-back register and data
//   ram_addr        SRAM word address (addr[ADDR_W+1:2])
//   ram_wdata       data to SRAM; ram_wdata_oe enables the bus driver
//   ram_rdata       data from SRAM
//   ram_ce_n, ram_oe_n, ram_we_n, ram_be_n  active-low SRAM controls
module mem_access
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              load_byte_i,
    input  logic              reg_write_i,
    input  logic [4:0]        wreg_i,
    output logic              busy,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_reg,
    output logic [31:0]       wb_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wdata_oe,
    input  logic [31:0]       ram_rdata,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [3:0]        ram_be_n
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              wait_done;
    logic              mem_req;
    logic              wr_phase;

    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              load_byte_q;
    logic              reg_write_q;
    logic [4:0]        wreg_q;

    logic [31:0]       ld_data;
    logic [31:0]       st_data;
    logic [3:0]        st_be_n;

    assign mem_req   = mem_read_i | mem_write_i;
    assign wait_done = (cnt == '0);

    mem_byte_lane u_lane (
        .lane      (addr_q[1:0]),
        .load_byte (load_byte_q),
        .rdata     (ram_rdata),
        .wdata     (wdata_q),
        .rd_data   (ld_data),
        .st_data   (st_data),
        .be_n      (st_be_n)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (mem_read_i)       state_nxt = ST_RD;
                else if (mem_write_i) state_nxt = ST_WR_SETUP;
            end
            ST_RD:       if (wait_done) state_nxt = ST_DONE;
            ST_WR_SETUP: state_nxt = ST_WR_PULSE;
            ST_WR_PULSE: if (wait_done) state_nxt = ST_WR_HOLD;
            ST_WR_HOLD:  state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // The counter reloads on every state change, so each multi-cycle state
    // starts with WAIT_CYCLES remaining and exits when it reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= CNT_LOAD;
            else if (!wait_done)
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            load_byte_q <= 1'b0;
            reg_write_q <= 1'b0;
            wreg_q      <= '0;
        end else if (state == ST_IDLE && mem_req) begin
            addr_q      <= addr_i[ADDR_W+1:0];
            wdata_q     <= wdata_i;
            load_byte_q <= load_byte_i;
            reg_write_q <= reg_write_i;
            wreg_q      <= wreg_i;
        end
    end

    // Write-back is registered on the edge that enters DONE (or on the IDLE
    // edge for a pass-through), so the pulse lines up with the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_reg       <= '0;
            wb_data      <= '0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            if (state == ST_IDLE && !mem_req) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= reg_write_i;
                wb_reg       <= wreg_i;
                wb_data      <= addr_i;
            end else if (state == ST_RD && wait_done) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= reg_write_q;
                wb_reg       <= wreg_q;
                wb_data      <= ld_data;
            end else if (state == ST_WR_HOLD) begin
                wb_valid <= 1'b1;
                wb_reg   <= wreg_q;
            end
        end
    end

    // Strobes decode the registered state, so reset forces them inactive
    // without waiting for a clock edge.
    assign wr_phase     = (state == ST_WR_SETUP) || (state == ST_WR_PULSE) ||
                          (state == ST_WR_HOLD);
    assign busy         = (state != ST_IDLE);
    assign ram_ce_n     = !((state == ST_RD) || wr_phase);
    assign ram_oe_n     = (state != ST_RD);
    assign ram_we_n     = (state != ST_WR_PULSE);
    assign ram_wdata_oe = wr_phase;
    assign ram_be_n     = (state == ST_RD) ? BE_ALL :
                          wr_phase         ? st_be_n : BE_NONE;
    assign ram_addr     = addr_q[ADDR_W+1:2];
    assign ram_wdata    = st_data;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed bench for mem_access against a
// transaction-level model that schedules the expected per-cycle outputs.
module tb_mem_access;

    localparam int W     = 1;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic        load_byte_i = 1'b0;
    logic        reg_write_i = 1'b0;
    logic [4:0]  wreg_i = '0;

    logic        busy, wb_valid, wb_reg_write;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [19:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_wdata_oe, ram_ce_n, ram_oe_n, ram_we_n;
    logic [3:0]  ram_be_n;

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(20), .WAIT_CYCLES(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .load_byte_i  (load_byte_i),
        .reg_write_i  (reg_write_i),
        .wreg_i       (wreg_i),
        .busy         (busy),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_wdata_oe (ram_wdata_oe),
        .ram_rdata    (ram_rdata),
        .ram_ce_n     (ram_ce_n),
        .ram_oe_n     (ram_oe_n),
        .ram_we_n     (ram_we_n),
        .ram_be_n     (ram_be_n)
    );

    function automatic logic [31:0] init_word(input int unsigned k);
        if (k == 4)  return 32'hDEADBEEF;
        if (k == 12) return 32'hCAFEF00D;
        return 32'h9E3779B9 * (k + 1);
    endfunction

    // Small SRAM: 16 words, aliased on ram_addr[3:0]; writes land mid-pulse.
    logic [31:0] sram [16];
    assign ram_rdata = sram[ram_addr[3:0]];

    initial begin
        for (int k = 0; k < 16; k++) sram[k] = init_word(k);
        forever begin
            @(negedge clk);
            if (!ram_ce_n && !ram_we_n)
                for (int b = 0; b < 4; b++)
                    if (!ram_be_n[b]) sram[ram_addr[3:0]][8*b +: 8] = ram_wdata[8*b +: 8];
        end
    end

    // Expected outputs for each cycle, filled in when a request is accepted.
    typedef struct packed {
        logic        busy, ce_n, oe_n, we_n;
        logic [3:0]  be_n;
        logic        doe, wbv, wbw, chk_wb, chk_addr, chk_wdata;
        logic [4:0]  wreg;
        logic [19:0] raddr;
        logic [31:0] wdata;
        logic [31:0] wbdata;
    } exp_t;

    exp_t        ex [DEPTH];
    int unsigned cyc = 0;
    int unsigned free_at = 0;
    logic [31:0] ref_mem [16];
    bit          pend_v = 1'b0;
    int unsigned pend_at = 0;
    logic [3:0]  pend_idx = '0;
    logic [31:0] pend_word = '0;

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.ce_n = 1'b1; e.oe_n = 1'b1; e.we_n = 1'b1; e.be_n = 4'hF;
        return e;
    endfunction

    task automatic put(input int unsigned k, input exp_t e);
        if (k < DEPTH) ex[k] = e;
    endtask

    task automatic accept(input int unsigned c);
        exp_t        e;
        logic [31:0] word, val, b, mask, nw;
        int unsigned sh;
        sh   = 8 * int'(addr_i[1:0]);
        word = ref_mem[addr_i[5:2]];
        if (mem_read_i) begin
            if (load_byte_i) begin
                b   = (word >> sh) & 32'hFF;
                val = (b >= 128) ? (b | 32'hFFFFFF00) : b;
            end else begin
                val = word;
            end
            e = idle_exp();
            e.busy = 1; e.ce_n = 0; e.oe_n = 0; e.be_n = 4'h0;
            e.chk_addr = 1; e.raddr = addr_i[21:2];
            for (int unsigned k = 1; k <= W + 1; k++) put(c + k, e);
            e = idle_exp();
            e.busy = 1; e.wbv = 1; e.wbw = reg_write_i; e.chk_wb = 1;
            e.wreg = wreg_i; e.wbdata = val;
            put(c + W + 2, e);
            free_at = c + W + 3;
        end else if (mem_write_i) begin
            e = idle_exp();
            e.busy = 1; e.ce_n = 0; e.doe = 1;
            e.be_n = load_byte_i ? (4'hF ^ (4'h1 << addr_i[1:0])) : 4'h0;
            e.chk_addr = 1; e.raddr = addr_i[21:2];
            e.chk_wdata = 1;
            e.wdata = load_byte_i ? (wdata_i & 32'hFF) * 32'h01010101 : wdata_i;
            put(c + 1, e);
            e.we_n = 0;
            for (int unsigned k = 2; k <= W + 2; k++) put(c + k, e);
            e.we_n = 1;
            put(c + W + 3, e);
            e = idle_exp();
            e.busy = 1; e.wbv = 1; e.wbw = 0;
            put(c + W + 4, e);
            if (load_byte_i) begin
                mask = 32'hFF << sh;
                nw   = (word & ~mask) | ((wdata_i & 32'hFF) << sh);
            end else begin
                nw = wdata_i;
            end
            pend_v = 1; pend_at = c + W + 4; pend_idx = addr_i[5:2]; pend_word = nw;
            free_at = c + W + 5;
        end else begin
            e = idle_exp();
            e.wbv = 1; e.wbw = reg_write_i; e.chk_wb = 1;
            e.wreg = wreg_i; e.wbdata = addr_i;
            put(c + 1, e);
            free_at = c + 1;
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) ex[k] = idle_exp();
        for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int unsigned k = cyc; k < cyc + 8; k++) put(k, idle_exp());
                pend_v  = 1'b0;
                free_at = cyc;
            end else begin
                if (pend_v && cyc == pend_at) begin
                    ref_mem[pend_idx] = pend_word;
                    pend_v = 1'b0;
                end
                if (cyc >= free_at) accept(cyc);
                cyc++;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
    endtask

    task automatic compare_cycle();
        exp_t e;
        e = (cyc < DEPTH) ? ex[cyc] : idle_exp();
        chk("ctrl{busy,ce,oe,we,be,oe_data,wbv}",
            {busy, ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, ram_wdata_oe, wb_valid},
            {e.busy, e.ce_n, e.oe_n, e.we_n, e.be_n, e.doe, e.wbv});
        chk("strobe_excl", {63'd0, !ram_we_n && !ram_oe_n}, 64'd0);
        if (e.wbv) chk("wb_reg_write", wb_reg_write, e.wbw);
        if (e.chk_wb) begin
            chk("wb_reg", wb_reg, e.wreg);
            chk("wb_data", wb_data, e.wbdata);
        end
        if (e.chk_addr)  chk("ram_addr", ram_addr, e.raddr);
        if (e.chk_wdata) chk("ram_wdata", ram_wdata, e.wdata);
    endtask

    task automatic adv();
        @(negedge clk);
        compare_cycle();
        #1;
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic lb, input logic rw,
                           input logic [4:0] wr_reg, input logic [31:0] a, input logic [31:0] d);
        mem_read_i = rd; mem_write_i = wr; load_byte_i = lb; reg_write_i = rw;
        wreg_i = wr_reg; addr_i = a; wdata_i = d;
    endtask

    task automatic nop();
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    initial begin
        nop();
        rst = 1'b1;
        adv(); adv(); adv();
        chk("rst_busy_wbv_wbw", {busy, wb_valid, wb_reg_write}, 3'b000);
        chk("rst_wb_reg", wb_reg, 5'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, ram_wdata_oe}, 8'b111_1111_0);
        chk("rst_ram_addr", ram_addr, 20'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        rst = 1'b0;
        adv(); adv();

        // LW 0x10 -> word 4 = DEADBEEF; a store presented while busy is ignored
        set_req(1, 0, 0, 1, 5'd5, 32'h10, 32'd0);
        adv();
        chk("lw_ram_addr", ram_addr, 20'd4);
        chk("lw_oe_n_c1", {busy, ram_oe_n}, 2'b10);
        set_req(0, 1, 0, 0, 5'd0, 32'h44, 32'hFFFFFFFF);
        adv();
        chk("lw_oe_n_c2", {ram_oe_n, ram_we_n}, 2'b01);
        adv();
        chk("lw_wb", {wb_valid, wb_reg_write, ram_oe_n}, 3'b111);
        chk("lw_wb_data", wb_data, 32'hDEADBEEF);
        chk("lw_wb_reg", wb_reg, 5'd5);
        nop();
        adv();
        chk("lw_idle", busy, 1'b0);

        // SW 0x10 <- 80112233
        set_req(0, 1, 0, 0, 5'd0, 32'h10, 32'h80112233);
        adv(); nop();
        adv(); adv(); adv(); adv(); adv();

        set_req(1, 0, 1, 1, 5'd9, 32'h13, 32'd0);
        adv(); nop(); adv(); adv();
        chk("lb13_wb_data", wb_data, 32'hFFFFFF80);
        adv();
        set_req(1, 0, 1, 1, 5'd9, 32'h11, 32'd0);
        adv(); nop(); adv(); adv();
        chk("lb11_wb_data", wb_data, 32'h00000022);
        adv();

        // SB 0x22 <- A5
        set_req(0, 1, 1, 1, 5'd1, 32'h22, 32'h000000A5);
        adv();
        chk("sb_be_n", ram_be_n, 4'b1011);
        chk("sb_wdata", ram_wdata, 32'hA5A5A5A5);
        chk("sb_setup", {ram_we_n, ram_wdata_oe, ram_ce_n}, 3'b110);
        nop();
        adv(); chk("sb_we_n_c2", ram_we_n, 1'b0);
        adv(); chk("sb_we_n_c3", ram_we_n, 1'b0);
        adv(); chk("sb_hold", {ram_we_n, ram_wdata_oe}, 2'b11);
        adv(); chk("sb_done", {wb_valid, wb_reg_write, busy}, 3'b101);
        adv();

        // ADD then LW back-to-back
        set_req(0, 0, 0, 1, 5'd7, 32'h12345678, 32'd0);
        adv();
        chk("add_wb", {wb_valid, wb_reg_write, busy}, 3'b110);
        chk("add_wb_data", wb_data, 32'h12345678);
        chk("add_wb_reg", wb_reg, 5'd7);
        set_req(1, 0, 0, 1, 5'd3, 32'h10, 32'd0);
        adv(); chk("b2b_busy1", busy, 1'b1);
        set_req(1, 0, 0, 1, 5'd4, 32'h40, 32'd0);
        adv(); chk("b2b_busy2", busy, 1'b1);
        adv(); chk("b2b_busy3", busy, 1'b1);
        chk("b2b_wb_data", wb_data, 32'h80112233);
        nop();
        adv(); chk("b2b_idle", busy, 1'b0);

        // Reset during WR_PULSE abandons the store
        set_req(0, 1, 0, 0, 5'd0, 32'h30, 32'h11223344);
        adv(); nop();
        @(posedge clk); #1;
        chk("rstp_we_low", ram_we_n, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstp_async", {ram_we_n, ram_wdata_oe, busy, ram_ce_n}, 4'b1001);
        adv(); adv();
        rst = 1'b0;
        adv(); adv();
        set_req(1, 0, 0, 1, 5'd6, 32'h30, 32'd0);
        adv(); nop(); adv(); adv();
        chk("rstp_lw_data", wb_data, 32'hCAFEF00D);
        adv();

        // read and write together: read only
        set_req(1, 1, 0, 1, 5'd2, 32'h10, 32'h0BADF00D);
        adv(); chk("rw_c1", {ram_we_n, ram_oe_n}, 2'b10);
        nop();
        adv(); chk("rw_c2", ram_we_n, 1'b1);
        adv(); chk("rw_done", {wb_valid, ram_we_n}, 2'b11);
        chk("rw_wb_data", wb_data, 32'h80112233);
        adv();

        for (int i = 0; i < 1500; i++) begin
            set_req(($urandom % 4) == 0, ($urandom % 4) == 0, $urandom % 2, $urandom % 2,
                    5'($urandom_range(0, 31)), $urandom, $urandom);
            adv();
        end
        nop();
        for (int i = 0; i < 10; i++) adv();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
